// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle.
// Groups the three handshakes around the fetch stage:
//   - redirect from execute:   br_taken, br_target
//   - instruction memory:      imem_req, imem_addr (out), imem_ack, imem_data (in)
//   - decode valid/ready:      inst, inst_pc, inst_valid (out), inst_ready (in)
// Modport master is the fetch sequencer; slave is the surrounding pipeline and memory.
interface fetch_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             br_taken;
  logic [WIDTH-1:0] br_target;

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_data;

  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_valid;
  logic             inst_ready;

  modport master (
    input  br_taken, br_target, imem_ack, imem_data, inst_ready,
    output imem_req, imem_addr, inst, inst_pc, inst_valid
  );

  modport slave (
    output br_taken, br_target, imem_ack, imem_data, inst_ready,
    input  imem_req, imem_addr, inst, inst_pc, inst_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the 16-bit CPU.
// Owns the PC, issues one instruction-memory request at a time, holds the returned
// word for decode over valid/ready, and redirects fetch to the branch-adder target.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_sequencer_if.master (redirect, imem request/ack, decode valid/ready)
// All bus outputs are registered.
module fetch_sequencer #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(1)
) (
  input logic                clk,
  input logic                rst,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             req_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] inst_q;
  logic [WIDTH-1:0] inst_pc_q;
  logic             valid_q;

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (!req_q) begin
            // Only reached on the first cycle after reset; any ack seen here belongs
            // to a request that reset aborted, so it is ignored.
            req_q <= 1'b1;
            if (bus.br_taken) begin
              pc_q   <= bus.br_target;
              addr_q <= bus.br_target;
            end else begin
              addr_q <= pc_q;
            end
          end else if (bus.imem_ack) begin
            if (bus.br_taken) begin
              // Returned word is on the wrong path: drop it and re-request at target.
              pc_q   <= bus.br_target;
              addr_q <= bus.br_target;
            end else begin
              inst_q    <= bus.imem_data;
              inst_pc_q <= pc_q;
              valid_q   <= 1'b1;
              pc_q      <= pc_q + PC_INC;
              req_q     <= 1'b0;
              state_q   <= StHold;
            end
          end else if (bus.br_taken) begin
            // Request cannot be withdrawn; wait out its ack and drop the data.
            pc_q    <= bus.br_target;
            state_q <= StDiscard;
          end
        end

        StHold: begin
          // Redirect outranks acceptance: the held word is flushed.
          if (bus.br_taken) begin
            valid_q <= 1'b0;
            pc_q    <= bus.br_target;
            req_q   <= 1'b1;
            addr_q  <= bus.br_target;
            state_q <= StFetch;
          end else if (bus.inst_ready) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= StFetch;
          end
        end

        StDiscard: begin
          if (bus.imem_ack) begin
            // Latest redirect wins, including one arriving with the ack.
            if (bus.br_taken) begin
              pc_q   <= bus.br_target;
              addr_q <= bus.br_target;
            end else begin
              addr_q <= pc_q;
            end
            state_q <= StFetch;
          end else if (bus.br_taken) begin
            pc_q <= bus.br_target;
          end
        end

        default: begin
          state_q <= StFetch;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, sequential fetch, backpressure, redirects
// in HOLD / FETCH / DISCARD, reset mid-operation, and PC wrap-around.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer_if #(.WIDTH(16)) b0 ();
  fetch_sequencer_if #(.WIDTH(16)) b1 ();

  fetch_sequencer #(.WIDTH(16), .RESET_PC(16'h0000), .PC_INC(16'd1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  fetch_sequencer #(.WIDTH(16), .RESET_PC(16'hFFFE), .PC_INC(16'd1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory answers one cycle after the request is seen.
  task automatic fetch0(input logic [15:0] d);
    b0.imem_ack = 1'b0;
    tick();
    b0.imem_ack  = 1'b1;
    b0.imem_data = d;
    tick();
    b0.imem_ack = 1'b0;
  endtask

  task automatic do_reset0();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.imem_ack = 1'b1;
    tick();
    checks++; if (b0.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid0 got %0h want 0", b0.inst_valid); end
    tick();
    checks++; if (b0.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", b0.imem_req); end
    checks++; if (b0.imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", b0.imem_addr); end
    checks++; if (b0.inst !== 16'h0000) begin errors++; $display("FAIL rst_inst got %h want 0000", b0.inst); end
    checks++; if (b0.inst_pc !== 16'h0000) begin errors++; $display("FAIL rst_inst_pc got %h want 0000", b0.inst_pc); end
    checks++; if (b0.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid1 got %0h want 0", b0.inst_valid); end
    rst = 1'b0;
    b0.imem_ack = 1'b0;
    tick();
    checks++; if (b0.imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req got %0h want 1", b0.imem_req); end
    checks++; if (b0.imem_addr !== 16'h0000) begin errors++; $display("FAIL post_rst_addr got %h want 0000", b0.imem_addr); end
  endtask

  task automatic test_sequential();
    b0.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'(i)) begin errors++; $display("FAIL seq_req[%0d] got req=%0h addr=%h want req=1 addr=%h", i, b0.imem_req, b0.imem_addr, 16'(i)); end
      fetch0(16'(16'hA000 + i));
      checks++; if (b0.inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %0h want 1", i, b0.inst_valid); end
      checks++; if (b0.inst !== 16'(16'hA000 + i)) begin errors++; $display("FAIL seq_inst[%0d] got %h want %h", i, b0.inst, 16'(16'hA000 + i)); end
      checks++; if (b0.inst_pc !== 16'(i)) begin errors++; $display("FAIL seq_inst_pc[%0d] got %h want %h", i, b0.inst_pc, 16'(i)); end
      checks++; if (b0.imem_req !== 1'b0) begin errors++; $display("FAIL seq_hold_req[%0d] got %0h want 0", i, b0.imem_req); end
      tick();
    end
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0003) begin errors++; $display("FAIL seq_addr3 got req=%0h addr=%h want req=1 addr=0003", b0.imem_req, b0.imem_addr); end
    checks++; if (b0.inst_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_drop got %0h want 0", b0.inst_valid); end
  endtask

  task automatic test_backpressure();
    do_reset0();
    b0.inst_ready = 1'b1;
    fetch0(16'hA000);
    tick();
    b0.inst_ready = 1'b0;
    fetch0(16'hA001);
    for (int k = 0; k < 5; k++) begin
      checks++; if (b0.inst !== 16'hA001 || b0.inst_pc !== 16'h0001 || b0.inst_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got inst=%h pc=%h v=%0h want A001 0001 1", k, b0.inst, b0.inst_pc, b0.inst_valid); end
      checks++; if (b0.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d] got %0h want 0", k, b0.imem_req); end
      tick();
    end
    b0.inst_ready = 1'b1;
    tick();
    b0.inst_ready = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0002) begin errors++; $display("FAIL bp_next got req=%0h addr=%h want req=1 addr=0002", b0.imem_req, b0.imem_addr); end
    checks++; if (b0.inst_valid !== 1'b0) begin errors++; $display("FAIL bp_valid got %0h want 0", b0.inst_valid); end
  endtask

  task automatic test_redirect_hold();
    b0.inst_ready = 1'b1;
    fetch0(16'hA002);
    tick();
    fetch0(16'hA003);
    tick();
    b0.inst_ready = 1'b0;
    fetch0(16'hA004);
    checks++; if (b0.inst_pc !== 16'h0004 || b0.inst_valid !== 1'b1) begin errors++; $display("FAIL rh_pre got pc=%h v=%0h want 0004 1", b0.inst_pc, b0.inst_valid); end
    b0.br_taken   = 1'b1;
    b0.br_target  = 16'h0040;
    b0.inst_ready = 1'b1;
    tick();
    b0.br_taken   = 1'b0;
    b0.inst_ready = 1'b0;
    checks++; if (b0.inst_valid !== 1'b0) begin errors++; $display("FAIL rh_flush got %0h want 0", b0.inst_valid); end
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0040) begin errors++; $display("FAIL rh_addr got req=%0h addr=%h want req=1 addr=0040", b0.imem_req, b0.imem_addr); end
    fetch0(16'hA040);
    checks++; if (b0.inst !== 16'hA040 || b0.inst_pc !== 16'h0040) begin errors++; $display("FAIL rh_inst got inst=%h pc=%h want A040 0040", b0.inst, b0.inst_pc); end
  endtask

  task automatic test_redirect_outstanding();
    // Redirect from HOLD to put a request on address 7.
    b0.br_taken  = 1'b1;
    b0.br_target = 16'h0007;
    tick();
    b0.br_taken = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0007) begin errors++; $display("FAIL ro_req7 got req=%0h addr=%h want req=1 addr=0007", b0.imem_req, b0.imem_addr); end
    tick();
    b0.br_taken  = 1'b1;
    b0.br_target = 16'h0100;
    tick();
    b0.br_taken = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0007 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL ro_disc got req=%0h addr=%h v=%0h want 1 0007 0", b0.imem_req, b0.imem_addr, b0.inst_valid); end
    tick();
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0007) begin errors++; $display("FAIL ro_held got req=%0h addr=%h want req=1 addr=0007", b0.imem_req, b0.imem_addr); end
    b0.imem_ack  = 1'b1;
    b0.imem_data = 16'hDEAD;
    tick();
    b0.imem_ack = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0100 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL ro_target got req=%0h addr=%h v=%0h want 1 0100 0", b0.imem_req, b0.imem_addr, b0.inst_valid); end
    // Two redirects while discarding: the later one wins.
    b0.br_taken  = 1'b1;
    b0.br_target = 16'h0300;
    tick();
    b0.br_target = 16'h0200;
    tick();
    b0.br_taken = 1'b0;
    checks++; if (b0.imem_addr !== 16'h0100 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL ro_disc2 got addr=%h v=%0h want 0100 0", b0.imem_addr, b0.inst_valid); end
    b0.imem_ack  = 1'b1;
    b0.imem_data = 16'hBEEF;
    tick();
    b0.imem_ack = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0200 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL ro_latest got req=%0h addr=%h v=%0h want 1 0200 0", b0.imem_req, b0.imem_addr, b0.inst_valid); end
    fetch0(16'hA200);
    checks++; if (b0.inst !== 16'hA200 || b0.inst_pc !== 16'h0200 || b0.inst_valid !== 1'b1) begin errors++; $display("FAIL ro_inst got inst=%h pc=%h v=%0h want A200 0200 1", b0.inst, b0.inst_pc, b0.inst_valid); end
    // Redirect coinciding with ack in FETCH: data dropped, request goes to target.
    b0.inst_ready = 1'b1;
    tick();
    b0.inst_ready = 1'b0;
    b0.imem_ack   = 1'b1;
    b0.imem_data  = 16'h1111;
    b0.br_taken   = 1'b1;
    b0.br_target  = 16'h0050;
    tick();
    b0.imem_ack = 1'b0;
    b0.br_taken = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0050 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL ro_ackbr got req=%0h addr=%h v=%0h want 1 0050 0", b0.imem_req, b0.imem_addr, b0.inst_valid); end
    fetch0(16'hA050);
    checks++; if (b0.inst !== 16'hA050 || b0.inst_pc !== 16'h0050) begin errors++; $display("FAIL ro_inst50 got inst=%h pc=%h want A050 0050", b0.inst, b0.inst_pc); end
  endtask

  task automatic test_reset_mid();
    // Reset while in HOLD.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b0.imem_req !== 1'b0 || b0.imem_addr !== 16'h0000 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL rm_hold got req=%0h addr=%h v=%0h want 0 0000 0", b0.imem_req, b0.imem_addr, b0.inst_valid); end
    checks++; if (b0.inst !== 16'h0000 || b0.inst_pc !== 16'h0000) begin errors++; $display("FAIL rm_hold_inst got inst=%h pc=%h want 0000 0000", b0.inst, b0.inst_pc); end
    b0.imem_ack  = 1'b1;
    b0.imem_data = 16'h5555;
    tick();
    b0.imem_ack = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0000 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL rm_late_ack got req=%0h addr=%h v=%0h want 1 0000 0", b0.imem_req, b0.imem_addr, b0.inst_valid); end
    fetch0(16'hA000);
    checks++; if (b0.inst !== 16'hA000 || b0.inst_pc !== 16'h0000 || b0.inst_valid !== 1'b1) begin errors++; $display("FAIL rm_restart got inst=%h pc=%h v=%0h want A000 0000 1", b0.inst, b0.inst_pc, b0.inst_valid); end
    // Reset while in DISCARD.
    b0.inst_ready = 1'b1;
    tick();
    b0.inst_ready = 1'b0;
    b0.br_taken   = 1'b1;
    b0.br_target  = 16'h0080;
    tick();
    b0.br_taken = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0001) begin errors++; $display("FAIL rm_disc_pre got req=%0h addr=%h want 1 0001", b0.imem_req, b0.imem_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b0.imem_req !== 1'b0 || b0.imem_addr !== 16'h0000 || b0.inst_valid !== 1'b0 || b0.inst !== 16'h0000) begin errors++; $display("FAIL rm_disc got req=%0h addr=%h v=%0h inst=%h want 0 0000 0 0000", b0.imem_req, b0.imem_addr, b0.inst_valid, b0.inst); end
    b0.imem_ack = 1'b1;
    tick();
    b0.imem_ack = 1'b0;
    checks++; if (b0.imem_req !== 1'b1 || b0.imem_addr !== 16'h0000 || b0.inst_valid !== 1'b0) begin errors++; $display("FAIL rm_disc_restart got req=%0h addr=%h v=%0h want 1 0000 0", b0.imem_req, b0.imem_addr, b0.inst_valid); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [3];
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000};
    b1.inst_ready = 1'b1;
    rst1 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (b1.imem_req !== 1'b1 || b1.imem_addr !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr[%0d] got req=%0h addr=%h want 1 %h", i, b1.imem_req, b1.imem_addr, exp_addr[i]); end
      b1.imem_ack  = 1'b1;
      b1.imem_data = 16'(16'hB000 + i);
      tick();
      b1.imem_ack = 1'b0;
      checks++; if (b1.inst_pc !== exp_addr[i] || b1.inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc[%0d] got pc=%h v=%0h want %h 1", i, b1.inst_pc, b1.inst_valid, exp_addr[i]); end
      tick();
    end
  endtask

  initial begin
    b0.br_taken = 1'b0; b0.br_target = '0; b0.imem_ack = 1'b0; b0.imem_data = '0;
    b0.inst_ready = 1'b0;
    b1.br_taken = 1'b0; b1.br_target = '0; b1.imem_ack = 1'b0; b1.imem_data = '0;
    b1.inst_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_hold();
    test_redirect_outstanding();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and drives the instruction-memory request interface. It is the consumer end of the branch-target path: it takes the PC + offset target computed by the branch adder and redirects fetch to it.
- Delivers one fetched instruction at a time to decode over a valid/ready handshake.
- Sits between the instruction memory and the decode stage of the 16-bit CPU.

Parameters:
- WIDTH, 16, width of PC, addresses and instruction words.
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 1, sequential PC increment (word-addressed memory).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- br_taken  input  1  single-cycle redirect request from execute.
- br_target  input  WIDTH  redirect address from the branch adder; sampled only when br_taken=1.
- imem_req  output  1  fetch request; registered.
- imem_addr  output  WIDTH  fetch address; registered, equals the PC of the outstanding request.
- imem_ack  input  1  one-cycle acknowledge; imem_data is valid in the same cycle.
- imem_data  input  WIDTH  instruction word returned by memory.
- inst  output  WIDTH  held instruction word.
- inst_pc  output  WIDTH  address inst was fetched from.
- inst_valid  output  1  inst/inst_pc are valid.
- inst_ready  input  1  decode accepts inst this cycle.

Behaviour:
- Reset (rst=1 at clk edge):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC, inst=0, inst_pc=0, inst_valid=0.
  - First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
  - Reset mid-request aborts everything immediately; a late imem_ack arriving after reset is ignored (state is FETCH with req=0 for that cycle).
- States: FETCH, HOLD, DISCARD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Once asserted, imem_req stays high until imem_ack (protocol rule, never withdrawn).
  - On imem_ack and br_taken=0: inst<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+PC_INC (mod 2^WIDTH), imem_req<=0, go to HOLD.
  - On br_taken and imem_ack in the same cycle: data dropped, pc<=br_target, stay in FETCH. Next cycle imem_req=1 with imem_addr=br_target.
  - On br_taken without imem_ack: pc<=br_target, go to DISCARD; req stays 1 on the old address.
- HOLD:
  - inst_valid=1; inst and inst_pc are stable while valid and not accepted.
  - On inst_ready and br_taken=0: inst_valid<=0, go to FETCH; imem_req=1 the next cycle with imem_addr=pc.
  - On br_taken (priority over inst_ready): inst_valid<=0 (flush), pc<=br_target, go to FETCH.
- DISCARD:
  - imem_req=1 on the old address until imem_ack. Data is dropped, inst_valid stays 0.
  - On imem_ack: go to FETCH; next cycle imem_addr=pc (the redirect target).
  - A further br_taken while in DISCARD overwrites pc; the latest target wins.
  - br_taken and imem_ack in the same cycle: pc<=br_target, go to FETCH.
- Timing:
  - Best-case throughput is one instruction per 3 cycles (req, ack→HOLD, ready→FETCH).
  - Latency from imem_ack to inst_valid is 1 cycle.
- Arithmetic: PC increment is unsigned and wraps: 16'hFFFF + 1 = 16'h0000. br_target is used verbatim (no alignment or masking).
- Invariants:
  - inst_valid=1 only in HOLD.
  - imem_req=0 in HOLD and during rst.
  - At most one outstanding request.

Test Plan:
- Reset then sequential fetch: rst for 2 cycles; memory acks each request 1 cycle after req with data 16'hA000+addr; inst_ready tied 1 → imem_addr sequence 0,1,2,3; inst/inst_pc pairs (A000,0),(A001,1),(A002,2); inst_valid never high during rst.
- Backpressure: inst_ready=0 for 5 cycles with inst=16'hA001 held → inst/inst_pc stable, imem_req=0 throughout; after ready=1, next imem_addr=2.
- Redirect in HOLD: holding inst_pc=4, pulse br_taken with br_target=16'h0040 alongside inst_ready=1 → inst_valid drops next cycle, the instruction is not counted as accepted, next imem_addr=16'h0040.
- Redirect during outstanding request: req on addr 7 with ack delayed 3 cycles, br_taken with target 16'h0100 in cycle 1 → req held on 7 until ack, returned data dropped (inst_valid stays 0), next request addr 16'h0100; a second br_taken to 16'h0200 during DISCARD → next request 16'h0200.
- Wrap-around: RESET_PC=16'hFFFE → fetch addresses FFFE, FFFF, 0000.
- Reset mid-operation: assert rst in HOLD and in DISCARD → next cycle all outputs at reset values, a late ack is ignored, fetch restarts at RESET_PC.
